// File: rtl/string_edit_ctrl.sv
// string_edit_ctrl -- edit-request controller for a fixed-capacity character
// shift buffer. It turns key requests (char / backspace / clear) into single
// load/add/delete pulses, tracks how many characters are held, and runs the
// POV display scan index that selects which character is shown.
module string_edit_ctrl #(
  parameter int NCHARS = 11,
  parameter int CW     = 7,
  parameter int NW     = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          key_valid,
  output logic          key_ready,
  input  logic [1:0]    key_op,
  input  logic [CW-1:0] key_char,
  output logic          load,
  output logic          add,
  output logic          delete,
  output logic [CW-1:0] muxOut,
  output logic [NW-1:0] char_count,
  output logic          full,
  output logic          empty,
  output logic          err,
  input  logic          scan_tick,
  output logic [NW-1:0] char_sel,
  output logic          frame_start
);

  typedef enum logic [1:0] {
    S_INIT   = 2'd0,
    S_IDLE   = 2'd1,
    S_EXEC   = 2'd2,
    S_SETTLE = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    OP_CHAR  = 2'b00,
    OP_BKSP  = 2'b01,
    OP_CLEAR = 2'b10,
    OP_RSVD  = 2'b11
  } op_t;

  localparam logic [NW-1:0] CNT_FULL = NW'(NCHARS);
  localparam logic [NW-1:0] SEL_LAST = NW'(NCHARS - 1);
  localparam logic [NW-1:0] ONE      = NW'(1);

  state_t        state, next_state;

  // Next values of every registered output.
  logic          key_ready_d;
  logic          load_d, add_d, delete_d, err_d, frame_start_d;
  logic [CW-1:0] mux_d;
  logic [NW-1:0] count_d, sel_d;
  logic          full_d, empty_d;

  // key_ready is registered from next_state, so it always equals (state == S_IDLE)
  // and can double as the acceptance qualifier.
  logic accept;
  assign accept = key_valid && key_ready;

  // State register; reset parks the FSM in INIT so release reissues load.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values of the others; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_INIT;
    else        state <= next_state;
  end

  // Next-state logic. INIT lingers until its load pulse has been issued.
  always_comb begin
    next_state = state;
    unique case (state)
      S_INIT:   next_state = load ? S_IDLE : S_INIT;
      S_IDLE:   next_state = accept ? S_EXEC : S_IDLE;
      S_EXEC:   next_state = S_SETTLE;
      S_SETTLE: next_state = S_IDLE;
    endcase
  end

  // Output logic: decide pulses, count and scan values to register at this edge.
  // Pulses computed on acceptance are therefore visible during EXEC.
  // NOTE: every variable gets a default at the top of the block so no path
  // leaves it unassigned; a missing default would infer a latch.
  always_comb begin
    key_ready_d   = (next_state == S_IDLE);
    load_d        = 1'b0;
    add_d         = 1'b0;
    delete_d      = 1'b0;
    err_d         = 1'b0;
    mux_d         = muxOut;
    count_d       = char_count;
    sel_d         = char_sel;
    frame_start_d = 1'b0;

    if (state == S_INIT && !load) begin
      load_d = 1'b1;
    end else if (accept) begin
      unique case (op_t'(key_op))
        OP_CHAR: begin
          mux_d = key_char;
          if (full) begin
            err_d = 1'b1;
          end else begin
            add_d   = 1'b1;
            count_d = char_count + ONE;
          end
        end
        OP_BKSP: begin
          if (empty) begin
            err_d = 1'b1;
          end else begin
            delete_d = 1'b1;
            count_d  = char_count - ONE;
          end
        end
        OP_CLEAR: begin
          load_d  = 1'b1;
          count_d = '0;
        end
        OP_RSVD: begin
          err_d = 1'b1;
        end
      endcase
    end

    full_d  = (count_d == CNT_FULL);
    empty_d = (count_d == '0);

    // A load blanks the buffer, so the scan restarts a frame and ignores any tick.
    if (load_d) begin
      sel_d         = '0;
      frame_start_d = 1'b1;
    end else if (scan_tick) begin
      if (char_sel == SEL_LAST) begin
        sel_d         = '0;
        frame_start_d = 1'b1;
      end else begin
        sel_d = char_sel + ONE;
      end
    end
  end

  // Output registers; asynchronous reset aborts any pulse in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_ready   <= 1'b0;
      load        <= 1'b0;
      add         <= 1'b0;
      delete      <= 1'b0;
      err         <= 1'b0;
      muxOut      <= '0;
      char_count  <= '0;
      full        <= 1'b0;
      empty       <= 1'b1;
      char_sel    <= '0;
      frame_start <= 1'b0;
    end else begin
      key_ready   <= key_ready_d;
      load        <= load_d;
      add         <= add_d;
      delete      <= delete_d;
      err         <= err_d;
      muxOut      <= mux_d;
      char_count  <= count_d;
      full        <= full_d;
      empty       <= empty_d;
      char_sel    <= sel_d;
      frame_start <= frame_start_d;
    end
  end

endmodule

// File: tb/tb_string_edit_ctrl.sv
// Testbench for string_edit_ctrl: directed scenarios plus a randomized run,
// every cycle compared against a queue-based model of the character buffer.
module tb_string_edit_ctrl;

  localparam int NCHARS = 11;
  localparam int CW     = 7;
  localparam int NW     = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          key_valid;
  logic          key_ready;
  logic [1:0]    key_op;
  logic [CW-1:0] key_char;
  logic          load, add, delete, err, full, empty, frame_start;
  logic [CW-1:0] muxOut;
  logic [NW-1:0] char_count, char_sel;
  logic          scan_tick;

  string_edit_ctrl #(.NCHARS(NCHARS), .CW(CW), .NW(NW)) dut (
    .clk(clk), .rst_n(rst_n),
    .key_valid(key_valid), .key_ready(key_ready),
    .key_op(key_op), .key_char(key_char),
    .load(load), .add(add), .delete(delete), .muxOut(muxOut),
    .char_count(char_count), .full(full), .empty(empty), .err(err),
    .scan_tick(scan_tick), .char_sel(char_sel), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: buffer contents as a queue, a busy-cycle counter for
  // request spacing, and the scan index as plain modular arithmetic.
  logic [CW-1:0] q[$];
  logic [CW-1:0] e_mux;
  logic          e_load, e_add, e_del, e_err, e_fs, m_ready, init_pending;
  int            m_busy, m_sel;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("load",        32'(load),        32'(e_load));
    check("add",         32'(add),         32'(e_add));
    check("delete",      32'(delete),      32'(e_del));
    check("err",         32'(err),         32'(e_err));
    check("muxOut",      32'(muxOut),      32'(e_mux));
    check("char_count",  32'(char_count),  32'(q.size()));
    check("full",        32'(full),        32'(q.size() == NCHARS));
    check("empty",       32'(empty),       32'(q.size() == 0));
    check("key_ready",   32'(key_ready),   32'(m_ready));
    check("char_sel",    32'(char_sel),    32'(m_sel));
    check("frame_start", 32'(frame_start), 32'(e_fs));
  endtask

  task automatic model_reset();
    q.delete();
    e_mux = '0; e_load = 0; e_add = 0; e_del = 0; e_err = 0; e_fs = 0;
    m_ready = 0; m_busy = 0; m_sel = 0; init_pending = 1;
  endtask

  task automatic model_edge(input logic v, input logic [1:0] op,
                            input logic [CW-1:0] ch, input logic tk);
    logic acc;
    acc = v && m_ready;
    e_load = 0; e_add = 0; e_del = 0; e_err = 0; e_fs = 0;
    if (init_pending) begin
      e_load = 1; init_pending = 0; m_busy = 1;
    end else if (acc) begin
      m_busy = 2;
      case (op)
        2'b00: begin
          e_mux = ch;
          if (q.size() < NCHARS) begin q.push_back(ch); e_add = 1; end
          else e_err = 1;
        end
        2'b01: begin
          if (q.size() > 0) begin void'(q.pop_back()); e_del = 1; end
          else e_err = 1;
        end
        2'b10: begin q.delete(); e_load = 1; end
        default: e_err = 1;
      endcase
    end else if (m_busy > 0) begin
      m_busy--;
    end
    m_ready = (m_busy == 0);
    if (e_load) begin
      m_sel = 0; e_fs = 1;
    end else if (tk) begin
      e_fs  = (m_sel == NCHARS - 1);
      m_sel = (m_sel + 1) % NCHARS;
    end
  endtask

  // One clock: drive at the falling edge, model the rising edge, check at the next fall.
  task automatic step(input logic v, input logic [1:0] op,
                      input logic [CW-1:0] ch, input logic tk);
    key_valid = v; key_op = op; key_char = ch; scan_tick = tk;
    @(posedge clk);
    model_edge(v, op, ch, tk);
    @(negedge clk);
    key_valid = 0; scan_tick = 0;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 2'b00, '0, 0);
  endtask

  // Issue one request when ready (bounded wait), then let it run through EXEC/SETTLE.
  task automatic req(input logic [1:0] op, input logic [CW-1:0] ch);
    for (int i = 0; i < 8 && !m_ready; i++) idle(1);
    check("ready_before_req", 32'(key_ready), 32'd1);
    step(1, op, ch, 0);
    step(1, 2'b00, 7'h5A, 0);   // held valid during EXEC must be ignored
    idle(1);
  endtask

  initial begin
    rst_n = 0; key_valid = 0; key_op = '0; key_char = '0; scan_tick = 0;
    model_reset();

    // Reset values, with inputs toggling during reset.
    repeat (2) @(negedge clk);
    key_valid = 1; scan_tick = 1;
    @(negedge clk);
    key_valid = 0; scan_tick = 0;
    check_all();

    // Release: load for one cycle, ready two edges after release.
    rst_n = 1;
    idle(4);

    // Three characters A, B, C.
    req(2'b00, 7'h41);
    req(2'b00, 7'h42);
    req(2'b00, 7'h43);

    // Fill past capacity: 12 chars total in buffer attempts.
    for (int i = 0; i < 9; i++) req(2'b00, 7'(7'h44 + i));
    check("count_full", 32'(char_count), 32'(NCHARS));

    // Clear, backspace on empty, two chars, backspace, clear, reserved op.
    req(2'b10, '0);
    req(2'b01, '0);
    req(2'b00, 7'h31);
    req(2'b00, 7'h32);
    req(2'b01, '0);
    req(2'b10, '0);
    req(2'b11, 7'h7F);

    // Scan: tick every 4 cycles across more than a full frame.
    for (int i = 0; i < 52; i++) step(0, 2'b00, '0, (i % 4) == 0);
    // Clear coincident with a scan tick.
    for (int i = 0; i < 8 && !m_ready; i++) idle(1);
    check("sel_nonzero", 32'(char_sel != 0), 32'd1);
    step(1, 2'b10, '0, 1);
    idle(2);

    // Reset asserted during EXEC of an add.
    for (int i = 0; i < 8 && !m_ready; i++) idle(1);
    key_valid = 1; key_op = 2'b00; key_char = 7'h55;
    @(posedge clk);
    model_edge(1, 2'b00, 7'h55, 0);
    #1;
    check("add_in_exec", 32'(add), 32'd1);
    #1 rst_n = 0;
    #1;
    key_valid = 0;
    model_reset();
    check_all();
    @(negedge clk);
    rst_n = 1;
    idle(3);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      logic [1:0] op;
      int r;
      r  = $urandom_range(0, 99);
      op = (r < 60) ? 2'b00 : (r < 85) ? 2'b01 : (r < 95) ? 2'b10 : 2'b11;
      step(1'($urandom_range(0, 1)), op, 7'($urandom_range(32, 126)),
           1'($urandom_range(0, 3) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/string_edit_ctrl.md
STRING_EDIT_CTRL -- requirements
Module: string_edit_ctrl

Interface
REQ-001 Parameter: NCHARS, 11, character capacity of the downstream 77-bit string shift buffer.
REQ-002 Parameter: CW, 7, character code width.
REQ-003 Parameter: NW, 4, width of count/index outputs; must hold NCHARS.
REQ-004 Port: clk  in  1  single clock; all state on rising edge.
REQ-005 Port: rst_n  in  1  reset, asynchronous, active-low.
REQ-006 Port: key_valid  in  1  edit request valid.
REQ-007 Port: key_ready  out  1  controller can accept a request.
REQ-008 Port: key_op  in  2  00 = char, 01 = backspace, 10 = clear, 11 = reserved.
REQ-009 Port: key_char  in  CW  character for a char op.
REQ-010 Port: load  out  1  buffer clear-to-spaces pulse.
REQ-011 Port: add  out  1  buffer shift-in pulse.
REQ-012 Port: delete  out  1  buffer shift-out pulse.
REQ-013 Port: muxOut  out  CW  character presented to buffer with add.
REQ-014 Port: char_count  out  NW  characters currently entered.
REQ-015 Port: full, empty  out  1 each  char_count==NCHARS / char_count==0.
REQ-016 Port: err  out  1  one-cycle pulse on rejected request.
REQ-017 Port: scan_tick  in  1  display column-advance strobe.
REQ-018 Port: char_sel  out  NW  POV scan character index.
REQ-019 Port: frame_start  out  1  one-cycle pulse when char_sel wraps to 0.

Function
REQ-020 All outputs shall be registered.
REQ-021 FSM states: INIT, IDLE, EXEC, SETTLE.
REQ-022 INIT: entered from reset; asserts load for exactly one cycle, then goes to IDLE.
REQ-023 key_ready shall be 1 only in IDLE; a request is accepted on a clk edge with key_valid && key_ready.
REQ-024 On acceptance: key_op and key_char are captured; FSM goes to EXEC.
REQ-025 EXEC (1 cycle): at most one of load/add/delete is high; FSM then goes to SETTLE.
REQ-026 SETTLE (1 cycle): no pulses, absorbs buffer update latency; FSM then returns to IDLE; minimum request spacing is 3 cycles.
REQ-027 Char op with !full: add=1, muxOut=captured key_char, char_count+1.
REQ-028 Char op with full: no add, err=1 during EXEC, count unchanged.
REQ-029 Backspace with !empty: delete=1, char_count-1; with empty: no delete, err=1.
REQ-030 Clear: load=1, char_count=0, accepted regardless of count.
REQ-031 Reserved op 11: no pulse, err=1, count unchanged.
REQ-032 muxOut shall hold its last value except when updated at acceptance of a char op.
REQ-033 char_count never exceeds NCHARS and never goes below 0.
REQ-034 Scan: on scan_tick, char_sel increments; from NCHARS-1 it wraps to 0 with frame_start=1 the following cycle.
REQ-035 Scan runs in every FSM state.
REQ-036 Any load pulse (INIT or clear) forces char_sel=0 and pulses frame_start; this takes priority over a simultaneous scan_tick.
REQ-037 key_valid while key_ready=0 shall be ignored, not queued.

Reset
REQ-038 While rst_n=0: state=INIT, load/add/delete/err/frame_start=0, muxOut=0, char_count=0, char_sel=0, key_ready=0.
REQ-039 Reset asserted mid-operation shall abort immediately; no pulse is completed. On release, INIT reissues load.

Verification
REQ-040 Release reset -> load=1 for exactly 1 cycle, key_ready=1 two cycles later, char_count=0, empty=1.
REQ-041 Three char ops 'A'(7'h41), 'B', 'C' -> three add pulses with muxOut 41/42/43, char_count=3, key_ready low 2 cycles after each.
REQ-042 12 char ops -> 11 adds, full=1 after the 11th, 12th gives err=1 and no add, char_count=11.
REQ-043 Backspace when empty -> err=1, no delete; after 2 chars, backspace -> delete=1, char_count=1; clear -> load=1, char_count=0.
REQ-044 scan_tick every 4 cycles -> char_sel 0..10, wraps after 10 with frame_start pulse; clear coincident with a scan_tick -> char_sel=0.
REQ-045 Assert rst_n=0 during EXEC of an add -> add drops immediately, outputs at reset values; INIT load follows release.
